// File: rtl/imm_encoder_pkg.sv
// Shared definitions for RISC-V immediate formats: type encodings, field masks
// and helpers used by the packer (and by the datapath's decode unit).
package imm_encoder_pkg;

    localparam int IMM_W = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_type_e;

    // Instruction bits owned by each format's immediate field
    localparam logic [IMM_W-1:0] MASK_I    = 32'hFFF0_0000;
    localparam logic [IMM_W-1:0] MASK_S    = 32'hFE00_0F80;
    localparam logic [IMM_W-1:0] MASK_B    = 32'hFE00_0F80;
    localparam logic [IMM_W-1:0] MASK_J    = 32'hFFFF_F000;
    localparam logic [IMM_W-1:0] MASK_U    = 32'hFFFF_F000;
    localparam logic [IMM_W-1:0] MASK_NONE = 32'h0000_0000;

    function automatic logic type_valid(input logic [2:0] sel);
        return (sel <= 3'(IMM_U));
    endfunction

    function automatic logic [IMM_W-1:0] type_mask(input logic [2:0] sel);
        logic [IMM_W-1:0] m;
        case (sel)
            3'(IMM_I): m = MASK_I;
            3'(IMM_S): m = MASK_S;
            3'(IMM_B): m = MASK_B;
            3'(IMM_J): m = MASK_J;
            3'(IMM_U): m = MASK_U;
            default:   m = MASK_NONE;
        endcase
        return m;
    endfunction

    // Inverse of the packer; kept here so the decode unit shares one definition
    function automatic logic [IMM_W-1:0] imm_decode(input logic [2:0] sel,
                                                    input logic [IMM_W-1:0] inst);
        logic [IMM_W-1:0] v;
        case (sel)
            3'(IMM_I): v = {{20{inst[31]}}, inst[31:20]};
            3'(IMM_S): v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            3'(IMM_B): v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
            3'(IMM_J): v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            3'(IMM_U): v = {inst[31:12], 12'h000};
            default:   v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/imm_if.sv
// Stream bundle of the immediate encoder: input transfer, output word and
// error statistics. master drives the input side, slave is the encoder.
interface imm_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_type;
    logic [DW-1:0] in_base;
    logic [DW-1:0] in_imm;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_inst;
    logic [AW-1:0] out_addr;
    logic          out_err;
    logic [7:0]    err_cnt;

    modport master (
        output in_valid, in_type, in_base, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_type, in_base, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
    );
endinterface

// File: rtl/imm_encoder_pack.sv
// Combinational immediate packer: scatters the immediate into the selected
// format's bit positions over the base word and flags unrepresentable values.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]       type_sel,
    input  logic [IMM_W-1:0] imm,
    input  logic [IMM_W-1:0] base,
    output logic [IMM_W-1:0] inst,
    output logic             err
);

    logic [IMM_W-1:0] mask;
    logic [IMM_W-1:0] field;
    logic             fits_12;
    logic             fits_13;
    logic             fits_21;
    logic             low12_zero;

    // A value fits an N-bit signed field when everything from bit N-1 up is sign copy
    assign fits_12    = (imm[31:11] == {21{imm[31]}});
    assign fits_13    = (imm[31:12] == {20{imm[31]}});
    assign fits_21    = (imm[31:20] == {12{imm[31]}});
    assign low12_zero = (imm[11:0] == 12'h000);

    assign mask = type_mask(type_sel);

    always_comb begin
        field = '0;
        err   = 1'b0;
        case (type_sel)
            3'(IMM_I): begin
                field[31:20] = imm[11:0];
                err          = !fits_12;
            end
            3'(IMM_S): begin
                field[31:25] = imm[11:5];
                field[11:7]  = imm[4:0];
                err          = !fits_12;
            end
            3'(IMM_B): begin
                field[31]    = imm[12];
                field[30:25] = imm[10:5];
                field[11:8]  = imm[4:1];
                field[7]     = imm[11];
                err          = !fits_13 || imm[0];
            end
            3'(IMM_J): begin
                field[31]    = imm[20];
                field[30:21] = imm[10:1];
                field[20]    = imm[11];
                field[19:12] = imm[19:12];
                err          = !fits_21 || imm[0];
            end
            3'(IMM_U): begin
                field[31:12] = imm[31:12];
                err          = !low12_zero;
            end
            default: begin
                field = '0;
                err   = 1'b1;
            end
        endcase
    end

    // Invalid types have an empty mask, so the base passes through untouched
    assign inst = (base & ~mask) | (field & mask);

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder top: one registered output stage behind valid/ready,
// sequential word-address counter and saturating error counter.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input logic clk,
    input logic rst,
    imm_if.slave bus
);

    logic [DW-1:0] pack_inst;
    logic          pack_err;

    logic          valid_reg, valid_next;
    logic [DW-1:0] inst_reg,  inst_next;
    logic          err_reg,   err_next;
    logic [AW-1:0] addr_reg,  addr_next;
    logic [7:0]    err_cnt_reg, err_cnt_next;

    logic ready;
    logic accept;
    logic handshake;

    imm_pack u_pack (
        .type_sel (bus.in_type),
        .imm      (bus.in_imm),
        .base     (bus.in_base),
        .inst     (pack_inst),
        .err      (pack_err)
    );

    assign ready     = !valid_reg || bus.out_ready;
    assign accept    = bus.in_valid && ready;
    assign handshake = valid_reg && bus.out_ready;

    always_comb begin
        valid_next   = valid_reg;
        inst_next    = inst_reg;
        err_next     = err_reg;
        addr_next    = addr_reg;
        err_cnt_next = err_cnt_reg;

        if (accept) begin
            valid_next = 1'b1;
            inst_next  = pack_inst;
            err_next   = pack_err;
        end else if (handshake) begin
            valid_next = 1'b0;
        end

        // Address advances on delivery, so a word loaded in the same edge gets the next one
        if (handshake) begin
            addr_next = addr_reg + 1'b1;
            if (err_reg && (err_cnt_reg != 8'hFF)) begin
                err_cnt_next = err_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            inst_reg    <= '0;
            err_reg     <= 1'b0;
            addr_reg    <= '0;
            err_cnt_reg <= 8'h00;
        end else begin
            valid_reg   <= valid_next;
            inst_reg    <= inst_next;
            err_reg     <= err_next;
            addr_reg    <= addr_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_reg;
    assign bus.out_inst  = inst_reg;
    assign bus.out_err   = err_reg;
    assign bus.out_addr  = addr_reg;
    assign bus.err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and streamed checks of imm_encoder: packing, range errors,
// backpressure, address wrap, error-count saturation and async reset.
module tb_imm_encoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_if #(.DW(32), .AW(10)) bus ();

    imm_encoder #(.DW(32), .AW(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_addr   = 0;
    int exp_errcnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_decode(input logic [2:0] t, input logic [31:0] i);
        case (t)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4:    return {i[31:12], 12'h000};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_mask(input logic [2:0] t);
        case (t)
            3'd0:       return 32'hFFF00000;
            3'd1, 3'd2: return 32'hFE000F80;
            3'd3, 3'd4: return 32'hFFFFF000;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] addr_of(input int a);
        return 32'(a % 1024);
    endfunction

    // One isolated word: drive, check presentation one cycle later, let it drain
    task automatic xfer(input string name, input logic [2:0] t, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] exp_inst, input logic exp_err);
        @(negedge clk);
        check({name, ".errcnt_before"}, 32'(bus.err_cnt), 32'(exp_errcnt));
        bus.in_valid = 1'b1;
        bus.in_type  = t;
        bus.in_base  = base;
        bus.in_imm   = imm;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({name, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({name, ".inst"},  bus.out_inst, exp_inst);
        check({name, ".err"},   32'(bus.out_err), 32'(exp_err));
        check({name, ".addr"},  32'(bus.out_addr), addr_of(exp_addr));
        $display("txn %s type=%0d base=%h imm=%h inst=%h addr=%0d err=%0b",
                 name, t, base, imm, bus.out_inst, bus.out_addr, bus.out_err);
        exp_addr++;
        if (exp_err && exp_errcnt < 255) exp_errcnt++;
    endtask

    // Back-to-back stream with out_ready high; each word is checked the cycle after it is driven
    task automatic stream(input int n, input bit make_err);
        logic [2:0]  pt;
        logic [31:0] pbase, pimm, r;
        bit have;
        have = 1'b0;
        pt = 3'd0; pbase = '0; pimm = '0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (have) begin
                check("st.valid", 32'(bus.out_valid), 32'd1);
                check("st.addr", 32'(bus.out_addr), addr_of(exp_addr));
                if (make_err) begin
                    check("st.inst_pass", bus.out_inst, pbase);
                    check("st.err1", 32'(bus.out_err), 32'd1);
                end else begin
                    check("st.roundtrip", ref_decode(pt, bus.out_inst), pimm);
                    check("st.basebits", bus.out_inst & ~ref_mask(pt), pbase & ~ref_mask(pt));
                    check("st.err0", 32'(bus.out_err), 32'd0);
                end
                $display("txn stream type=%0d imm=%h inst=%h addr=%0d err=%0b",
                         pt, pimm, bus.out_inst, bus.out_addr, bus.out_err);
                exp_addr++;
                if (make_err && exp_errcnt < 255) exp_errcnt++;
            end
            if (k < n) begin
                r     = $urandom;
                pbase = $urandom;
                if (make_err) begin
                    pt   = 3'($urandom_range(5, 7));
                    pimm = $urandom;
                end else begin
                    pt = 3'($urandom_range(0, 4));
                    case (pt)
                        3'd0, 3'd1: pimm = {{21{r[11]}}, r[10:0]};
                        3'd2:       pimm = {{20{r[12]}}, r[11:1], 1'b0};
                        3'd3:       pimm = {{12{r[20]}}, r[19:1], 1'b0};
                        default:    pimm = {r[31:12], 12'h000};
                    endcase
                end
                bus.in_valid = 1'b1;
                bus.in_type  = pt;
                bus.in_base  = pbase;
                bus.in_imm   = pimm;
                have = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
                have = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_type   = 3'd0;
        bus.in_base   = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b1;
        #23;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.valid",   32'(bus.out_valid), 32'd0);
        check("rst.inst",    bus.out_inst, 32'd0);
        check("rst.err",     32'(bus.out_err), 32'd0);
        check("rst.addr",    32'(bus.out_addr), 32'd0);
        check("rst.errcnt",  32'(bus.err_cnt), 32'd0);
        check("rst.inready", 32'(bus.in_ready), 32'd1);

        xfer("i_neg1",   3'd0, 32'h00000013, 32'hFFFFFFFF, 32'hFFF00013, 1'b0);
        xfer("b_8",      3'd2, 32'h00000063, 32'h00000008, 32'h00000463, 1'b0);
        xfer("j_odd",    3'd3, 32'h0000006F, 32'h00000003, 32'h0020006F, 1'b1);
        xfer("s_2048",   3'd1, 32'h00000023, 32'h00000800, 32'h80000023, 1'b1);
        xfer("u_ok",     3'd4, 32'h00000037, 32'h12345000, 32'h12345037, 1'b0);
        xfer("u_low",    3'd4, 32'h00000037, 32'h12345001, 32'h12345037, 1'b1);
        xfer("bad_type", 3'd5, 32'hDEADBEEF, 32'h00000123, 32'hDEADBEEF, 1'b1);
        xfer("i_min",    3'd0, 32'hFFFFFFFF, 32'hFFFFF800, 32'h800FFFFF, 1'b0);
        xfer("i_max",    3'd0, 32'h00000013, 32'h000007FF, 32'h7FF00013, 1'b0);
        xfer("j_min",    3'd3, 32'h0000006F, 32'hFFF00000, 32'h8000006F, 1'b0);

        // Backpressure: word A held for three stalled cycles while word B waits
        @(negedge clk);
        check("bp.errcnt", 32'(bus.err_cnt), 32'(exp_errcnt));
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_type   = 3'd0;
        bus.in_base   = 32'h00000013;
        bus.in_imm    = 32'h00000001;
        @(negedge clk);
        check("bp.a_valid", 32'(bus.out_valid), 32'd1);
        check("bp.a_inst",  bus.out_inst, 32'h00100013);
        bus.in_type = 3'd1;
        bus.in_base = 32'h00000023;
        bus.in_imm  = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp.inready", 32'(bus.in_ready), 32'd0);
            check("bp.hold_inst", bus.out_inst, 32'h00100013);
            check("bp.hold_addr", 32'(bus.out_addr), addr_of(exp_addr));
            check("bp.hold_err", 32'(bus.out_err), 32'd0);
            $display("txn stall cycle=%0d inst=%h addr=%0d", c, bus.out_inst, bus.out_addr);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.inready_release", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp.b_inst", bus.out_inst, 32'hFE000FA3);
        check("bp.b_addr", 32'(bus.out_addr), addr_of(exp_addr + 1));
        check("bp.b_err",  32'(bus.out_err), 32'd0);
        $display("txn bp_b inst=%h addr=%0d", bus.out_inst, bus.out_addr);
        exp_addr += 2;

        stream(10000, 1'b0);
        stream(300, 1'b1);
        @(negedge clk);
        check("sat.errcnt", 32'(bus.err_cnt), 32'(exp_errcnt));
        check("sat.errcnt255", 32'(bus.err_cnt), 32'd255);
        check("sat.addr", 32'(bus.out_addr), addr_of(exp_addr));

        // Asynchronous reset while an errored word is held under backpressure
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_type   = 3'd6;
        bus.in_base   = 32'hABCD0013;
        bus.in_imm    = 32'h0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid.valid", 32'(bus.out_valid), 32'd1);
        check("mid.err",   32'(bus.out_err), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst.valid",  32'(bus.out_valid), 32'd0);
        check("arst.inst",   bus.out_inst, 32'd0);
        check("arst.err",    32'(bus.out_err), 32'd0);
        check("arst.addr",   32'(bus.out_addr), 32'd0);
        check("arst.errcnt", 32'(bus.err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        exp_addr   = 0;
        exp_errcnt = 0;
        #1;
        check("arst.inready", 32'(bus.in_ready), 32'd1);
        xfer("post_rst", 3'd0, 32'h00000013, 32'h00000007, 32'h00700013, 1'b0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Streaming RISC-V immediate packer, the inverse of the datapath's immediate decode. Each transfer carries an instruction word with its immediate fields don't-care, a format select and a 32-bit immediate value. The block scatters the immediate into the format's bit positions, range-checks it, and emits the finished word with a sequential word address. It sits between the bootloader/test-program source and instruction memory, behind valid/ready handshakes.

## Interface
- `DW`, 32, data/instruction width (fixed at 32; other values unsupported)
- `AW`, 10, instruction-memory word-address width
- `clk` in 1, clock, all state on rising edge
- `rst` in 1, asynchronous active-high reset
- `in_valid` in 1, input transfer offered
- `in_ready` out 1, input transfer accepted this cycle when high with `in_valid`
- `in_type` in 3, immediate format: 000 I, 001 S, 010 B, 011 J, 100 U, 101–111 invalid
- `in_base` in DW, instruction word; bits belonging to the selected format's immediate are ignored
- `in_imm` in DW, immediate value (two's complement)
- `out_valid` out 1, output word valid
- `out_ready` in 1, downstream accepts
- `out_inst` out DW, packed instruction
- `out_addr` out AW, word address of `out_inst`
- `out_err` out 1, immediate was not representable in the selected format
- `err_cnt` out 8, saturating count of errored words delivered

## Operation
- Immediate field mask per format:
  - I: [31:20]
  - S: [31:25], [11:7]
  - B: [31:25], [11:7]
  - J: [31:12]
  - U: [31:12]
  - invalid: none
- `out_inst` = (`in_base` & ~mask) | packed immediate.
- Packing per format:
  - I: inst[31:20]=imm[11:0]
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11]
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]
  - U: inst[31:12]=imm[31:12]
- Range rules (`err`=1 if violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - Invalid type: always err, and `out_inst`=`in_base`.
- On error the word is still emitted, packed from truncated bits as above. Nothing is dropped.
- Round-trip invariant: for every non-errored word of a valid type, decoding `out_inst` with the same type returns `in_imm`.
- Address counter:
  - starts at 0.
  - increments by 1 on each output handshake (`out_valid`&&`out_ready`).
  - wraps 2^AW−1 → 0.
  - `out_addr` is the counter value at the time the word is presented.
- `err_cnt` increments on each output handshake with `out_err`=1 and saturates at 255.

## Timing
- Single registered output stage, latency 1: a word accepted at edge N is presented from cycle N+1.
- `in_ready` = !`out_valid` || `out_ready` (combinational). Full throughput of one word per cycle when `out_ready` stays high.
- While `out_valid`=1 and `out_ready`=0, `out_inst`, `out_addr` and `out_err` hold stable.
- Simultaneous output handshake and input accept: the new word loads and `out_addr` advances by 1 in the same edge.
- Reset (asynchronous, any time including mid-stream):
  - `out_valid`=0, `out_inst`=0, `out_err`=0, `out_addr`=0, `err_cnt`=0.
  - An in-flight word is discarded.
  - `in_ready`=1 while `rst` is deasserted with no word held.

## Structure
- Shared package holds:
  - `imm_type_e` enum (I/S/B/J/U encodings 000–100), shared with the decode unit's select.
  - per-format field-mask constants.
- Sub-module `imm_pack` (combinational): type + imm + base → packed word + err. The top level owns the register stage, handshake, address counter and error counter.

## Test plan
- I, `in_imm`=0xFFFFFFFF, base 0x00000013 → `out_inst`=0xFFF00013, `out_err`=0, `out_addr`=0, one cycle later.
- B, `in_imm`=8, base 0x00000063 → 0x00000463, err 0. J, `in_imm`=3 → `out_err`=1, `err_cnt`=1.
- S, `in_imm`=2048 → err 1. U, `in_imm`=0x12345000, base 0x37 → 0x12345037, err 0. U, 0x12345001 → err 1.
- Backpressure: `out_ready` low 3 cycles with `in_valid` high → `in_ready` low, outputs stable, `out_addr` unchanged, no word lost.
- Random round-trip: 10k valid in-range words, decode `out_inst` → equals `in_imm`. Addresses wrap at 2^AW. `err_cnt` saturates at 255 after 300 errors.
- Assert `rst` mid-burst with `out_valid`=1 → all outputs 0 immediately. Next word gets `out_addr`=0.
